// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the default operand width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // 2'd3 is never entered; the FSM treats it as IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = inp1 - inp2 - bin, with borrow-out.
// The difference is two cascaded XOR cells; the borrow is pure NAND logic.
module full_subtractor (
  input  logic inp1,
  input  logic inp2,
  input  logic bin,
  output logic diff,
  output logic bout
);

  logic x_ab;
  logic n_a;
  logic n_x;
  logic t_ab;
  logic t_xb;

  gate_xor u_xor_ab (
    .inp1 (inp1),
    .inp2 (inp2),
    .out  (x_ab)
  );

  gate_xor u_xor_d (
    .inp1 (x_ab),
    .inp2 (bin),
    .out  (diff)
  );

  // bout = (~a & b) | (~(a ^ b) & bin), written as a NAND-of-NANDs.
  assign n_a  = ~(inp1 & inp1);
  assign n_x  = ~(x_ab & x_ab);
  assign t_ab = ~(n_a & inp2);
  assign t_xb = ~(n_x & bin);
  assign bout = ~(t_ab & t_xb);

endmodule

// File: rtl/gate_xor.sv
// Two-input XOR gate, the basic difference-forming cell shared with the
// adder datapath.
module gate_xor (
  input  logic inp1,
  input  logic inp2,
  output logic out
);

  assign out = inp1 ^ inp2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: inp1 - inp2, one bit per clock,
// LSB first, framed by a start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-2:0] res_reg;
  logic [CW-1:0]    cnt_reg;
  logic             bor_reg;
  logic [WIDTH-1:0] out_reg;
  logic             borrow_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             d_bit;
  logic             bout_bit;
  logic [WIDTH-1:0] res_full;

  full_subtractor u_fs (
    .inp1 (a_reg[0]),
    .inp2 (b_reg[0]),
    .bin  (bor_reg),
    .diff (d_bit),
    .bout (bout_bit)
  );

  // The newest bit enters at the MSB; after WIDTH shifts bit 0 sits at position 0.
  // Only WIDTH-1 partial bits need storing since the last one comes straight from the cell.
  assign res_full = {d_bit, res_reg};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      cnt_reg    <= '0;
      bor_reg    <= 1'b0;
      out_reg    <= '0;
      borrow_reg <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          busy_reg <= 1'b0;
          done_reg <= 1'b0;
          if (start) begin
            a_reg     <= inp1;
            b_reg     <= inp2;
            res_reg   <= '0;
            cnt_reg   <= '0;
            bor_reg   <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          res_reg <= res_full[WIDTH-1:1];
          bor_reg <= bout_bit;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            out_reg    <= res_full;
            borrow_reg <= bout_bit;
            done_reg   <= 1'b1;
            state_reg  <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign out    = out_reg;
  assign borrow = borrow_reg;

endmodule
